// File: rtl/mdu_pkg.sv
// Shared operation codes, latencies and FSM state type for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage to multiply/divide unit connection: operation, operands, busy and read result.
interface mdu_if;
  logic [3:0]  mdOp;
  logic        start;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] mdRes;

  modport master (output mdOp, start, srcA, srcB, input busy, mdRes);
  modport slave  (input mdOp, start, srcA, srcB, output busy, mdRes);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; the result is staged at start and
// committed when the fixed-latency countdown expires.
module mdu
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  mdu_state_e  r_state, w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_hi_next, r_lo_next;
  logic        r_div0;

  logic        w_accept, w_commit, w_b_zero;
  logic [3:0]  w_lat;
  logic [31:0] w_hi_calc, w_lo_calc;

  logic [31:0] w_a, w_b;
  assign w_a = bus.srcA;
  assign w_b = bus.srcB;

  // Products
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  assign w_prod_s = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});
  assign w_prod_u = {32'd0, w_a} * {32'd0, w_b};

  // Signed division works on magnitudes so 0x80000000 / -1 cannot overflow.
  logic [31:0] w_abs_a, w_abs_b, w_dvs_s, w_dvs_u;
  logic [31:0] w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;
  assign w_b_zero = (w_b == 32'd0);
  assign w_abs_a  = w_a[31] ? -w_a : w_a;
  assign w_abs_b  = w_b[31] ? -w_b : w_b;
  assign w_dvs_s  = w_b_zero ? 32'd1 : w_abs_b;
  assign w_dvs_u  = w_b_zero ? 32'd1 : w_b;
  assign w_q_mag  = w_abs_a / w_dvs_s;
  assign w_r_mag  = w_abs_a % w_dvs_s;
  assign w_q_s    = (w_a[31] ^ w_b[31]) ? -w_q_mag : w_q_mag;
  assign w_r_s    = w_a[31] ? -w_r_mag : w_r_mag;
  assign w_q_u    = w_a / w_dvs_u;
  assign w_r_u    = w_a % w_dvs_u;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_hi_calc = w_prod_s[63:32];
    w_lo_calc = w_prod_s[31:0];
    w_lat     = 4'(MDU_MULT_CYC);
    case (bus.mdOp)
      MD_MULTU: begin
        w_hi_calc = w_prod_u[63:32];
        w_lo_calc = w_prod_u[31:0];
      end
      MD_DIV: begin
        w_hi_calc = w_r_s;
        w_lo_calc = w_q_s;
        w_lat     = 4'(MDU_DIV_CYC);
      end
      MD_DIVU: begin
        w_hi_calc = w_r_u;
        w_lo_calc = w_q_u;
        w_lat     = 4'(MDU_DIV_CYC);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && is_md_start(bus.mdOp)) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == 4'd1) begin
          w_commit     = !r_div0;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 4'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_div0 <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= w_lat;
        r_div0 <= is_md_div(bus.mdOp) && w_b_zero;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_hi <= r_hi_next;
        r_lo <= r_lo_next;
      end else if (r_state == ST_IDLE) begin
        if (bus.mdOp == MD_MTHI) r_hi <= w_a;
        if (bus.mdOp == MD_MTLO) r_lo <= w_a;
      end
    end
  end

  // NOTE: staging registers carry no reset; they are only read after a start has loaded them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hi_next <= w_hi_calc;
      r_lo_next <= w_lo_calc;
    end
  end

  assign bus.busy  = (r_state == ST_RUN);
  assign bus.mdRes = (bus.mdOp == MD_MFHI) ? r_hi :
                     (bus.mdOp == MD_MFLO) ? r_lo : 32'd0;

endmodule
